// File: rtl/block_ram_dp_param.sv
// Parametrised dual-port block RAM.
// Port A reads and writes with byte-lane enables; port B is read-only.
// Read latency is 1 cycle, or 2 cycles when OUT_REG=1, and each port has its own valid strobe.
// After reset, a zero-fill engine clears the whole array so the memory starts from a known image.
module block_ram_dp_param #(
  parameter int DATA_W         = 16,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int OUT_REG        = 0,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clka,
  input  logic                       rsta,
  input  logic                       ena,
  input  logic [DATA_W/BYTE_W-1:0]   wea,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [DATA_W-1:0]          dina,
  output logic [DATA_W-1:0]          douta,
  output logic                       vala,
  input  logic                       enb,
  input  logic [ADDR_W-1:0]          addrb,
  output logic [DATA_W-1:0]          doutb,
  output logic                       valb,
  output logic                       busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Addresses at or above DEPTH have no storage behind them.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_L);
  endfunction

  // Expand the per-lane write enables into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] we);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{we[i]}};
    end
    return m;
  endfunction

  // Take the masked lanes from the new data and keep every other lane of the stored word.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [DATA_W-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              clr_we;

  logic [IDX_W-1:0]  idxa, idxb;
  logic              a_in, b_in;
  logic              acc_a, acc_b, wr_a;
  logic [DATA_W-1:0] olda, oldb, mask_a, newa, rda;

  logic [DATA_W-1:0] a_s1_data_q, a_s1_data_d;
  logic [DATA_W-1:0] b_s1_data_q, b_s1_data_d;
  logic              a_s1_vld_q, a_s1_vld_d;
  logic              b_s1_vld_q, b_s1_vld_d;
  logic [DATA_W-1:0] douta_q, douta_d;
  logic [DATA_W-1:0] doutb_q, doutb_d;
  logic              vala_q, vala_d;
  logic              valb_q, valb_d;

  assign idxa = addra[IDX_W-1:0];
  assign idxb = addrb[IDX_W-1:0];

  // Clear engine: step through the array one word per cycle, then stop and release busy.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      default: begin
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Clear engine registers: reset restarts the clear at address 0.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Request qualification and the asynchronous array lookups that feed both read paths.
  always_comb begin
    a_in   = in_range(addra);
    b_in   = in_range(addrb);
    acc_a  = ena & ~busy_q & ~rsta;
    acc_b  = enb & ~busy_q & ~rsta;
    olda   = a_in ? mem[idxa] : '0;
    oldb   = b_in ? mem[idxb] : '0;
    mask_a = lane_mask(wea);
    newa   = merge_word(olda, dina, mask_a);
    wr_a   = acc_a & a_in & (|wea);
    if (WRITE_FIRST != 0) begin
      rda = a_in ? newa : '0;
    end else begin
      rda = olda;
    end
  end

  // Array write port: the clear engine and port A never overlap because busy blocks port A.
  always_ff @(posedge clka) begin
    if (clr_we && !rsta) begin
      mem[ptr_q] <= '0;
    end else if (wr_a) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) begin
          mem[idxa][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read pipeline: the optional second stage delays data and strobe together; outputs hold when idle.
  always_comb begin
    a_s1_vld_d  = acc_a;
    b_s1_vld_d  = acc_b;
    a_s1_data_d = acc_a ? rda  : a_s1_data_q;
    b_s1_data_d = acc_b ? oldb : b_s1_data_q;
    if (OUT_REG != 0) begin
      vala_d  = a_s1_vld_q;
      valb_d  = b_s1_vld_q;
      douta_d = a_s1_vld_q ? a_s1_data_q : douta_q;
      doutb_d = b_s1_vld_q ? b_s1_data_q : doutb_q;
    end else begin
      vala_d  = acc_a;
      valb_d  = acc_b;
      douta_d = acc_a ? rda  : douta_q;
      doutb_d = acc_b ? oldb : doutb_q;
    end
  end

  // Read pipeline registers: all read state returns to zero on reset.
  always_ff @(posedge clka) begin
    if (rsta) begin
      a_s1_vld_q  <= 1'b0;
      b_s1_vld_q  <= 1'b0;
      a_s1_data_q <= '0;
      b_s1_data_q <= '0;
      vala_q      <= 1'b0;
      valb_q      <= 1'b0;
      douta_q     <= '0;
      doutb_q     <= '0;
    end else begin
      a_s1_vld_q  <= a_s1_vld_d;
      b_s1_vld_q  <= b_s1_vld_d;
      a_s1_data_q <= a_s1_data_d;
      b_s1_data_q <= b_s1_data_d;
      vala_q      <= vala_d;
      valb_q      <= valb_d;
      douta_q     <= douta_d;
      doutb_q     <= doutb_d;
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;
  assign vala  = vala_q;
  assign valb  = valb_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_block_ram_dp_param.sv
// Bench for block_ram_dp_param: two configurations driven in lockstep against a behavioural memory model.
// d0: DEPTH=16, OUT_REG=0, read-first.  d1: DEPTH=12, OUT_REG=1, write-first (addresses 12..15 out of range).
module tb_block_ram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rsta, ena, enb;
  logic [1:0]  wea;
  logic [3:0]  addra, addrb;
  logic [15:0] dina;

  logic [15:0] douta0, doutb0, douta1, doutb1;
  logic        vala0, valb0, busy0, vala1, valb1, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  block_ram_dp_param #(
    .DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(16),
    .OUT_REG(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
  ) u_d0 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta0), .vala(vala0), .enb(enb), .addrb(addrb), .doutb(doutb0),
    .valb(valb0), .busy(busy0)
  );

  block_ram_dp_param #(
    .DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(12),
    .OUT_REG(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)
  ) u_d1 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta1), .vala(vala1), .enb(enb), .addrb(addrb), .doutb(doutb1),
    .valb(valb1), .busy(busy1)
  );

  // Reference model state, one slot per configuration.
  logic [15:0] m_mem   [2][16];
  bit          m_busy  [2];
  int          m_left  [2];
  bit          m_pva   [2];
  bit          m_pvb   [2];
  logic [15:0] m_pda   [2];
  logic [15:0] m_pdb   [2];
  bit          e_vala  [2];
  bit          e_valb  [2];
  logic [15:0] e_douta [2];
  logic [15:0] e_doutb [2];
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model of configuration k by one clock edge using the current inputs.
  task automatic model_edge(input int k);
    int          d;
    bit          lat2, wfirst, va, vb;
    logic [15:0] da, db, old, nw, mask;
    d      = (k == 0) ? 16 : 12;
    lat2   = (k == 1);
    wfirst = (k == 1);
    if (rsta) begin
      m_busy[k] = 1'b1;
      m_left[k] = d;
      m_pva[k] = 1'b0; m_pvb[k] = 1'b0; m_pda[k] = '0; m_pdb[k] = '0;
      e_vala[k] = 1'b0; e_valb[k] = 1'b0; e_douta[k] = '0; e_doutb[k] = '0;
      return;
    end
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    if (m_busy[k]) begin
      m_mem[k][d - m_left[k]] = '0;
      m_left[k]--;
      if (m_left[k] == 0) m_busy[k] = 1'b0;
    end else begin
      if (enb) begin
        vb = 1'b1;
        db = (int'(addrb) < d) ? m_mem[k][addrb] : 16'h0000;
      end
      if (ena) begin
        va   = 1'b1;
        old  = (int'(addra) < d) ? m_mem[k][addra] : 16'h0000;
        mask = {{8{wea[1]}}, {8{wea[0]}}};
        nw   = (old & ~mask) | (dina & mask);
        if (int'(addra) < d) begin
          m_mem[k][addra] = nw;
          da = wfirst ? nw : old;
        end
      end
    end
    if (lat2) begin
      e_vala[k] = m_pva[k];
      e_valb[k] = m_pvb[k];
      if (m_pva[k]) e_douta[k] = m_pda[k];
      if (m_pvb[k]) e_doutb[k] = m_pdb[k];
      m_pva[k] = va; m_pda[k] = da;
      m_pvb[k] = vb; m_pdb[k] = db;
    end else begin
      e_vala[k] = va;
      e_valb[k] = vb;
      if (va) e_douta[k] = da;
      if (vb) e_doutb[k] = db;
    end
  endtask

  // One clock: update models, take the edge, then compare every output of both instances.
  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
    chk("d0 busy",  32'(busy0),  32'(m_busy[0]));
    chk("d0 vala",  32'(vala0),  32'(e_vala[0]));
    chk("d0 douta", 32'(douta0), 32'(e_douta[0]));
    chk("d0 valb",  32'(valb0),  32'(e_valb[0]));
    chk("d0 doutb", 32'(doutb0), 32'(e_doutb[0]));
    chk("d1 busy",  32'(busy1),  32'(m_busy[1]));
    chk("d1 vala",  32'(vala1),  32'(e_vala[1]));
    chk("d1 douta", 32'(douta1), 32'(e_douta[1]));
    chk("d1 valb",  32'(valb1),  32'(e_valb[1]));
    chk("d1 doutb", 32'(doutb1), 32'(e_doutb[1]));
  endtask

  task automatic drive(input logic r, input logic ea, input logic [1:0] we, input logic [3:0] aa,
                       input logic [15:0] di, input logic eb, input logic [3:0] ab);
    rsta = r; ena = ea; wea = we; addra = aa; dina = di; enb = eb; addrb = ab;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall0, fall1;
    rsta = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; addra = '0; addrb = '0; dina = '0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_left[k] = 0;
      for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
    end

    // Reset, then traffic during the clear (ignored), then a mid-clear reset.
    drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
    chk("reset busy", 32'(busy0), 32'd1);
    chk("reset douta", 32'(douta0), 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (c == 5) drive(1'b0, 1'b1, 2'b11, 4'd2, 16'hFFFF, 1'b1, 4'd2);
      else        idle();
      chk("busy vala gated", 32'(vala0), 32'd0);
    end
    drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);

    // Measure how long busy stays high after the mid-clear reset.
    fall0 = -1; fall1 = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (fall0 < 0 && !busy0) fall0 = i;
      if (fall1 < 0 && !busy1) fall1 = i;
    end
    chk("clear length d0", 32'(fall0), 32'd16);
    chk("clear length d1", 32'(fall1), 32'd12);

    // Every word reads zero after the clear.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 2'b00, 4'(i), 16'h0000, 1'b1, 4'(i));
      chk("clear read vala", 32'(vala0), 32'd1);
      chk("clear read douta", 32'(douta0), 32'h0000);
      chk("clear read doutb", 32'(doutb0), 32'h0000);
    end
    idle();

    // Byte-lane writes.
    drive(1'b0, 1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 2'b01, 4'd5, 16'h0012, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5);
    chk("byte doutb d0", 32'(doutb0), 32'hBE12);
    chk("byte valb d0", 32'(valb0), 32'd1);
    idle();
    chk("byte valb pulse", 32'(valb0), 32'd0);
    chk("byte doutb d1", 32'(doutb1), 32'hBE12);

    // Read-during-write on address 3.
    drive(1'b0, 1'b1, 2'b11, 4'd3, 16'h1111, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 2'b11, 4'd3, 16'h2222, 1'b1, 4'd3);
    chk("rdw douta read-first", 32'(douta0), 32'h1111);
    chk("rdw doutb d0", 32'(doutb0), 32'h1111);
    idle();
    chk("rdw douta write-first", 32'(douta1), 32'h2222);
    chk("rdw doutb d1", 32'(doutb1), 32'h1111);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3);
    chk("rdw next doutb", 32'(doutb0), 32'h2222);
    idle();

    // Back-to-back reads through the two-stage pipeline.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'b11, 4'(i), 16'(16'hA0 + i), 1'b0, 4'd0);
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b0, 1'b1, 2'b00, 4'(i), 16'h0000, 1'b0, 4'd0);
      else       idle();
      chk("pipe vala", 32'(vala1), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 4) chk("pipe douta", 32'(douta1), 32'(16'hA0 + i - 1));
    end

    // Out-of-range write and read (only out of range for d1).
    drive(1'b0, 1'b1, 2'b11, 4'd13, 16'h5555, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 2'b00, 4'd13, 16'h0000, 1'b0, 4'd0);
    chk("in-range d0 douta", 32'(douta0), 32'h5555);
    idle();
    chk("oor vala", 32'(vala1), 32'd1);
    chk("oor douta", 32'(douta1), 32'h0000);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'(i));
    idle();
    idle();

    // Randomized traffic, with an occasional reset.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 3; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
